// File: rtl/lane_bitslip.sv
// -----------------------------------------------------------------------------
// lane_bitslip
//
// Per-lane half-bit realigner for a DDR LVDS ADC front end. It sits between
// the DDR input capture and the deserializer/word framer. Each lane carries a
// rise bit and a fall bit per dco_clk cycle. A bitslip pulse toggles a lane
// between normal order and an order shifted later by one half-bit. The framer
// uses this to hunt for word alignment.
//
// Ports
//   dco_clk       in   1      ADC data clock; both edges are used
//   rst_n         in   1      asynchronous active-low reset
//   in_rise       in   LANES  rise-edge data bit per lane (stable at posedge)
//   in_fall       in   LANES  fall-edge data bit per lane (stable at posedge)
//   bitslip_pulse in   LANES  per-lane slip request, sampled at posedge
//   out_rise      out  LANES  realigned rise bit, updates on posedge
//   out_fall      out  LANES  realigned fall bit, updates on negedge
// -----------------------------------------------------------------------------
module lane_bitslip #(
  parameter int LANES = 2
) (
  input  logic             dco_clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] in_rise,
  input  logic [LANES-1:0] in_fall,
  input  logic [LANES-1:0] bitslip_pulse,
  output logic [LANES-1:0] out_rise,
  output logic [LANES-1:0] out_fall
);

  // Captured copies of this cycle's bits, consumed by the following negedge
  // and, in slipped mode, by the next posedge.
  logic [LANES-1:0] r_rise_q;
  logic [LANES-1:0] r_fall_q;
  // 0 = normal order, 1 = slipped by half a bit.
  logic [LANES-1:0] r_slip_offset;
  logic [LANES-1:0] r_out_rise;
  logic [LANES-1:0] r_out_fall;

  logic [LANES-1:0] w_rise_sel;
  logic [LANES-1:0] w_fall_sel;

  // Per-lane output select. In slipped mode out_rise carries the previous
  // cycle's fall bit and out_fall carries this cycle's rise bit. The stream
  // therefore shifts later by one half-bit.
  always_comb begin
    w_rise_sel = (r_slip_offset & r_fall_q) | (~r_slip_offset & in_rise);
    w_fall_sel = (r_slip_offset & r_rise_q) | (~r_slip_offset & r_fall_q);
  end

  // Posedge state: capture inputs, drive out_rise, and toggle the offset.
  // out_rise still uses the old offset on the edge that samples the pulse.
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise_q      <= '0;
      r_fall_q      <= '0;
      r_slip_offset <= '0;
      r_out_rise    <= '0;
    end else begin
      r_rise_q      <= in_rise;
      r_fall_q      <= in_fall;
      r_slip_offset <= r_slip_offset ^ bitslip_pulse;
      r_out_rise    <= w_rise_sel;
    end
  end

  // Negedge output register. It sees the offset produced by the preceding
  // posedge, so a slip takes effect on the very next half-bit.
  always_ff @(negedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_fall <= '0;
    end else begin
      r_out_fall <= w_fall_sel;
    end
  end

  assign out_rise = r_out_rise;
  assign out_fall = r_out_fall;

endmodule

// File: tb/tb_lane_bitslip.sv
// -----------------------------------------------------------------------------
// tb_lane_bitslip
//
// Directed testbench for lane_bitslip with LANES=2. Each stimulus cycle pushes
// its hand-computed expectations into two queues. Independent monitors pop
// and compare the queues after every posedge (out_rise) and every negedge
// (out_fall).
// -----------------------------------------------------------------------------
module tb_lane_bitslip;

  logic       dco_clk;
  logic       rst_n;
  logic [1:0] in_rise;
  logic [1:0] in_fall;
  logic [1:0] bitslip_pulse;
  logic [1:0] out_rise;
  logic [1:0] out_fall;

  int n_cmp;
  int n_err;

  logic [1:0] q_rise[$];
  logic [1:0] q_fall[$];

  lane_bitslip #(.LANES(2)) dut (
    .dco_clk       (dco_clk),
    .rst_n         (rst_n),
    .in_rise       (in_rise),
    .in_fall       (in_fall),
    .bitslip_pulse (bitslip_pulse),
    .out_rise      (out_rise),
    .out_fall      (out_fall)
  );

  // 10 time-unit clock: posedges at 5, 15, ... and negedges at 10, 20, ...
  initial dco_clk = 1'b0;
  always #5 dco_clk = ~dco_clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // out_rise monitor: one expectation per posedge.
  always @(posedge dco_clk) begin
    #1;
    if (q_rise.size() > 0) check("out_rise", out_rise, q_rise.pop_front());
  end

  // out_fall monitor: one expectation per negedge.
  always @(negedge dco_clk) begin
    #1;
    if (q_fall.size() > 0) check("out_fall", out_fall, q_fall.pop_front());
  end

  // Drive one cycle just after a negedge, so the inputs are stable at the
  // next posedge. Queue what that posedge and the following negedge must show.
  task automatic drive(input logic [1:0] r, input logic [1:0] f, input logic [1:0] p,
                       input logic [1:0] exp_rise, input logic [1:0] exp_fall);
    @(negedge dco_clk);
    #2;
    in_rise       = r;
    in_fall       = f;
    bitslip_pulse = p;
    q_rise.push_back(exp_rise);
    q_fall.push_back(exp_fall);
  endtask

  // Hard watchdog so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    in_rise       = 2'b00;
    in_fall       = 2'b00;
    bitslip_pulse = 2'b00;

    // Reset held for two cycles with active data on the inputs.
    in_rise = 2'b11;
    in_fall = 2'b11;
    repeat (2) @(posedge dco_clk);
    #1;
    check("reset_out_rise", out_rise, 2'b00);
    check("reset_out_fall", out_fall, 2'b00);
    @(negedge dco_clk);
    #2;
    rst_n = 1'b1;

    //      in_rise in_fall pulse   exp_rise exp_fall
    // Normal mode: out_rise = r_k, out_fall = f_k.
    drive(2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
    drive(2'b01, 2'b10, 2'b00, 2'b01, 2'b10);
    drive(2'b10, 2'b01, 2'b00, 2'b10, 2'b01);
    // Slip both lanes: the posedge keeps the old offset and the negedge gives r_3.
    drive(2'b11, 2'b00, 2'b11, 2'b11, 2'b11);
    // Slipped: out_rise = f_3, out_fall = r_4.
    drive(2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    // Unslip both lanes (drops a half-bit): out_rise = f_4, then out_fall = f_5.
    drive(2'b01, 2'b10, 2'b11, 2'b11, 2'b10);
    // Lane 0 only slips; lane 1 stays normal.
    drive(2'b10, 2'b01, 2'b01, 2'b10, 2'b00);
    drive(2'b11, 2'b00, 2'b00, 2'b11, 2'b01);
    // Lane 0 pulsed again and returns to normal.
    drive(2'b01, 2'b01, 2'b01, 2'b00, 2'b01);
    drive(2'b10, 2'b10, 2'b00, 2'b10, 2'b10);
    // Pulse held two cycles on lane 0 leaves the offset unchanged.
    drive(2'b01, 2'b11, 2'b01, 2'b01, 2'b11);
    drive(2'b10, 2'b00, 2'b01, 2'b11, 2'b00);
    drive(2'b01, 2'b10, 2'b00, 2'b01, 2'b10);
    // Slip both lanes again, then run in slipped mode.
    drive(2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    drive(2'b11, 2'b11, 2'b00, 2'b00, 2'b11);
    drive(2'b01, 2'b00, 2'b00, 2'b11, 2'b01);

    // Mid-stream asynchronous reset while slipped with non-zero outputs.
    @(negedge dco_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_rise", out_rise, 2'b00);
    check("async_rst_out_fall", out_fall, 2'b00);
    repeat (2) @(posedge dco_clk);
    #1;
    check("held_rst_out_rise", out_rise, 2'b00);
    check("held_rst_out_fall", out_fall, 2'b00);
    @(negedge dco_clk);
    #2;
    rst_n = 1'b1;

    // After release the lanes run in normal mode.
    drive(2'b10, 2'b01, 2'b00, 2'b10, 2'b01);
    drive(2'b01, 2'b10, 2'b00, 2'b01, 2'b10);

    // Drain the queues with a bounded wait.
    repeat (3) @(posedge dco_clk);
    #3;
    if (q_rise.size() != 0 || q_fall.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d rise and %0d fall expectations left, required 0",
               q_rise.size(), q_fall.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
